wb_issue_arbiter: RTL and testbench

Registered write-back issue stage for the vector unit. It collects beats from WIDTH producer lanes, such as functional units and the load unit, over valid/ready handshakes and selects one lane per cycle by static priority, with lane 0 highest. A multi-beat burst keeps its lane locked until the final beat. Accepted beats are forwarded through a single output register to the vector-register-file write port.

---
 rtl/wb_issue_arbiter.sv | 136 +++++++++++++
 tb/tb_wb_issue_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_issue_arbiter.sv
// Write-back issue arbiter: static-priority lane select with burst lock and a
// single output register. Optional starvation ageing under `WB_AGE_EN.
module wb_issue_arbiter #(
  parameter int WIDTH   = 4,
  parameter int DATA_W  = 64,
  parameter int SRC_W   = 2,
  parameter int AGE_MAX = 15
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [WIDTH-1:0]        req_valid_i,
  input  logic [WIDTH-1:0]        req_last_i,
  input  logic [WIDTH*DATA_W-1:0] req_data_i,
  output logic [WIDTH-1:0]        req_ready_o,
  output logic                    wb_valid_o,
  output logic [DATA_W-1:0]       wb_data_o,
  output logic [SRC_W-1:0]        wb_src_o,
  output logic                    wb_last_o,
  input  logic                    wb_ready_i,
  output logic                    busy_o
);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e            state_q, state_d;
  logic [SRC_W-1:0]  owner_q, owner_d;
  logic              wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [SRC_W-1:0]  wb_src_q, wb_src_d;
  logic              wb_last_q, wb_last_d;

  logic              out_free;
  logic              acc;
  logic [WIDTH-1:0]  cand;
  logic [SRC_W-1:0]  sel;
  logic [DATA_W-1:0] sel_data;
  logic              sel_last;

`ifdef WB_AGE_EN
  localparam int AGE_W = $clog2(AGE_MAX + 1);
  logic [AGE_W-1:0] age_q [WIDTH];
  logic [AGE_W-1:0] age_d [WIDTH];
  logic [WIDTH-1:0] aged;
`endif

  always_comb begin
    out_free = !wb_valid_q || wb_ready_i;
    cand     = req_valid_i;
`ifdef WB_AGE_EN
    for (int i = 0; i < WIDTH; i++) begin
      aged[i] = req_valid_i[i] && (age_q[i] == AGE_W'(AGE_MAX));
    end
    if (|aged) cand = aged;
`endif
    sel = owner_q;
    if (state_q == IDLE) begin
      sel = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (cand[i]) sel = SRC_W'(i);
      end
    end

    req_ready_o = '0;
    sel_data    = '0;
    sel_last    = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (SRC_W'(i) == sel) begin
        req_ready_o[i] = out_free && !rst_i &&
                         ((state_q == IDLE) ? cand[i] : req_valid_i[i]);
        sel_data = req_data_i[i*DATA_W +: DATA_W];
        sel_last = req_last_i[i];
      end
    end
    acc = |req_ready_o;

    state_d    = state_q;
    owner_d    = owner_q;
    wb_valid_d = wb_valid_q;
    wb_data_d  = wb_data_q;
    wb_src_d   = wb_src_q;
    wb_last_d  = wb_last_q;
    if (acc) begin
      // Drain and accept in one cycle simply reloads: no bubble.
      wb_valid_d = 1'b1;
      wb_data_d  = sel_data;
      wb_src_d   = sel;
      wb_last_d  = sel_last;
      owner_d    = sel;
      state_d    = sel_last ? IDLE : LOCKED;
    end else if (wb_ready_i) begin
      wb_valid_d = 1'b0;
    end

`ifdef WB_AGE_EN
    for (int i = 0; i < WIDTH; i++) begin
      age_d[i] = age_q[i];
      if (!req_valid_i[i] || req_ready_o[i]) age_d[i] = '0;
      else if (age_q[i] != AGE_W'(AGE_MAX)) age_d[i] = age_q[i] + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_src_q   <= '0;
      wb_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_src_q   <= wb_src_d;
      wb_last_q  <= wb_last_d;
    end
  end

`ifdef WB_AGE_EN
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (rst_i) age_q[i] <= '0;
      else       age_q[i] <= age_d[i];
    end
  end
`endif

  assign wb_valid_o = wb_valid_q;
  assign wb_data_o  = wb_data_q;
  assign wb_src_o   = wb_src_q;
  assign wb_last_o  = wb_last_q;
  assign busy_o     = (state_q == LOCKED) || wb_valid_q;

endmodule

// File: tb/tb_wb_issue_arbiter.sv
// Scoreboard bench for wb_issue_arbiter: directed scenarios plus random
// bursts against a lane-queue reference model.
module tb_wb_issue_arbiter;
  localparam int WIDTH  = 4;
  localparam int DATA_W = 64;
  localparam int SRC_W  = 2;
`ifdef WB_AGE_EN
  localparam int AGE_MAX = 3;
`else
  localparam int AGE_MAX = 15;
`endif

  logic                    clk = 0;
  logic                    rst_i;
  logic [WIDTH-1:0]        req_valid_i;
  logic [WIDTH-1:0]        req_last_i;
  logic [WIDTH*DATA_W-1:0] req_data_i;
  logic [WIDTH-1:0]        req_ready_o;
  logic                    wb_valid_o;
  logic [DATA_W-1:0]       wb_data_o;
  logic [SRC_W-1:0]        wb_src_o;
  logic                    wb_last_o;
  logic                    wb_ready_i;
  logic                    busy_o;

  wb_issue_arbiter #(
    .WIDTH(WIDTH), .DATA_W(DATA_W), .SRC_W(SRC_W), .AGE_MAX(AGE_MAX)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_last_i(req_last_i),
    .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o),
    .wb_src_o(wb_src_o), .wb_last_o(wb_last_o),
    .wb_ready_i(wb_ready_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              l;
  } beat_t;
  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [SRC_W-1:0]  s;
    logic              l;
  } exp_t;

  beat_t lq [WIDTH][$];
  exp_t  sb [$];
  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] hs = '0;

  bit   m_locked = 0;
  bit   m_ov = 0;
  int   m_owner = 0;
  int   age [WIDTH];

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference model: predicts ready, busy and the beat stream from lane state.
  always @(negedge clk) begin
    logic [WIDTH-1:0] exp_rdy;
    int  g, ag;
    bit  free;
    exp_rdy = '0;
    g = -1;
    ag = -1;
    if (rst_i) begin
      m_locked = 0;
      m_ov = 0;
      sb.delete();
      for (int i = 0; i < WIDTH; i++) age[i] = 0;
      chk("ready_in_reset", 128'(req_ready_o), 128'(0));
      hs = '0;
    end else begin
      chk("busy", 128'(busy_o), 128'(m_locked || m_ov));
      chk("wb_valid", 128'(wb_valid_o), 128'(m_ov));
      free = !m_ov || wb_ready_i;
      if (m_locked) begin
        if (req_valid_i[m_owner]) g = m_owner;
      end else begin
        for (int i = WIDTH - 1; i >= 0; i--) begin
          if (req_valid_i[i]) g = i;
`ifdef WB_AGE_EN
          if (req_valid_i[i] && age[i] == AGE_MAX) ag = i;
`endif
        end
        if (ag >= 0) g = ag;
      end
      if (!free) g = -1;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", 128'(req_ready_o), 128'(exp_rdy));
      hs = req_valid_i & req_ready_o;
      if (m_ov && wb_ready_i) m_ov = 0;
      if (g >= 0) begin
        sb.push_back({req_data_i[g*DATA_W +: DATA_W], SRC_W'(g),
                      req_last_i[g]});
        m_ov = 1;
        m_locked = !req_last_i[g];
        m_owner = g;
      end
      for (int i = 0; i < WIDTH; i++) begin
        if (req_valid_i[i] && g != i) age[i] = (age[i] < AGE_MAX) ? age[i] + 1 : AGE_MAX;
        else age[i] = 0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever a beat leaves the output register.
  bit   stalled = 0;
  exp_t held;
  always @(negedge clk) begin
    exp_t e;
    if (rst_i) begin
      stalled = 0;
    end else begin
      if (stalled) chk("hold", 128'({wb_data_o, wb_src_o, wb_last_o}), 128'(held));
      if (wb_valid_o && wb_ready_i) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL beat_unexpected got src %0d want none", wb_src_o);
        end else begin
          e = sb.pop_front();
          chk("beat", 128'({wb_data_o, wb_src_o, wb_last_o}), 128'(e));
        end
      end
      stalled = wb_valid_o && !wb_ready_i;
      held = {wb_data_o, wb_src_o, wb_last_o};
    end
  end

  task automatic drive();
    for (int i = 0; i < WIDTH; i++) begin
      req_valid_i[i] = lq[i].size() > 0;
      req_last_i[i]  = (lq[i].size() > 0) ? lq[i][0].l : 1'b0;
      req_data_i[i*DATA_W +: DATA_W] = (lq[i].size() > 0) ? lq[i][0].d : '0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < WIDTH; i++) begin
      if (hs[i] && lq[i].size() > 0) void'(lq[i].pop_front());
    end
    drive();
  endtask

  task automatic burst(int lane, int n, logic [DATA_W-1:0] base);
    for (int k = 0; k < n; k++) lq[lane].push_back({base + DATA_W'(k), k == n - 1});
  endtask

  task automatic flush_lanes();
    for (int i = 0; i < WIDTH; i++) lq[i].delete();
  endtask

  task automatic drain();
    int n;
    bit busy_tb;
    wb_ready_i = 1'b1;
    n = 0;
    do begin
      cycle();
      n++;
      busy_tb = wb_valid_o || sb.size() > 0;
      for (int i = 0; i < WIDTH; i++) if (lq[i].size() > 0) busy_tb = 1;
    end while (busy_tb && n < 300);
    if (busy_tb) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got busy want idle");
    end
  endtask

  initial begin
    rst_i = 1'b1;
    wb_ready_i = 1'b1;
    req_valid_i = '0;
    req_last_i = '0;
    req_data_i = '0;
    repeat (2) cycle();
    rst_i = 1'b0;
    cycle();

    // single beat from lane 2
    lq[2].push_back({DATA_W'(64'hAB), 1'b1});
    drive();
    drain();

    // static priority 0,1,3
    burst(0, 1, 64'h100);
    burst(1, 1, 64'h200);
    burst(3, 1, 64'h300);
    drive();
    drain();

    // lane 3 burst holds lock against lane 0
    burst(3, 3, 64'h3000);
    drive();
    cycle();
    burst(0, 1, 64'h0A0);
    drive();
    drain();

    // backpressure while holding 0x11
    burst(0, 1, 64'h11);
    burst(1, 1, 64'h22);
    drive();
    cycle();
    wb_ready_i = 1'b0;
    repeat (4) cycle();
    wb_ready_i = 1'b1;
    drain();

    // reset in the middle of a lane 1 burst
    burst(1, 4, 64'h1000);
    drive();
    cycle();
    cycle();
    rst_i = 1'b1;
    flush_lanes();
    drive();
    cycle();
    rst_i = 1'b0;
    burst(1, 4, 64'h1100);
    burst(0, 1, 64'hF0);
    drive();
    drain();

    // two lanes continuously requesting single beats
    for (int k = 0; k < 8; k++) begin
      burst(0, 1, DATA_W'(64'hA00 + k));
      burst(2, 1, DATA_W'(64'hC00 + k));
    end
    drive();
    drain();

    // random bursts, backpressure and occasional reset
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (lq[i].size() == 0 && $urandom_range(3) == 0)
          burst(i, int'($urandom_range(1, 4)), {$urandom, $urandom});
      end
      wb_ready_i = ($urandom_range(3) != 0);
      if ($urandom_range(299) == 0) begin
        rst_i = 1'b1;
        flush_lanes();
      end
      drive();
      cycle();
      if (rst_i) begin
        rst_i = 1'b0;
        drive();
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
